// File: rtl/matrix_uart_printer.sv
// matrix_uart_printer: prints an m x n byte matrix as decimal ASCII rows over 8N1 UART.
// Define PRINT_HEADER_EN to prefix each valid print with an "m n\r\n" header line.
module matrix_uart_printer #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] dim_m,
    input  logic [2:0] dim_n,
    output logic       rd_en,
    output logic [4:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);
    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT,
        CONV,
        TX_DIGIT,
        TX_SEP,
        TX_CR,
        TX_LF,
        FINISH
`ifdef PRINT_HEADER_EN
        , TX_HDR
`endif
    } state_t;

    state_t state, state_n;

    logic [2:0] m_r, n_r, row, col;
    logic [4:0] addr;
    logic [7:0] val;
    logic [3:0] d2, d1, d0, cur_dig;
    logic [1:0] dig_idx;
    logic       dims_ok, last_col, last_row;
    logic       accept, next_elem, next_row, dig_step;

    logic          tx_active, tx_ready, tx_load;
    logic [7:0]    tx_byte;
    logic [9:0]    frame;
    logic [CW-1:0] bit_cyc;
    logic [3:0]    bit_idx;

`ifdef PRINT_HEADER_EN
    logic [2:0] hdr_idx;
    logic [7:0] hdr_byte;
    logic       hdr_step;
`endif

    assign dims_ok  = (dim_m != 3'd0) && (dim_m <= 3'd5) &&
                      (dim_n != 3'd0) && (dim_n <= 3'd5);
    assign last_col = (col == n_r - 3'd1);
    assign last_row = (row == m_r - 3'd1);
    assign cur_dig  = (dig_idx == 2'd2) ? d2 :
                      (dig_idx == 2'd1) ? d1 : d0;
    assign tx_ready = !tx_active;
    assign rd_addr  = addr;

`ifdef PRINT_HEADER_EN
    // Header byte sequence: m digit, space, n digit, CR, LF.
    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_byte = {5'b00110, m_r};
            3'd1:    hdr_byte = 8'h20;
            3'd2:    hdr_byte = {5'b00110, n_r};
            3'd3:    hdr_byte = 8'h0D;
            default: hdr_byte = 8'h0A;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and control strobes; the next element is fetched while
    // the separator or LF frame is still shifting out, keeping gaps short.
    always_comb begin
        state_n   = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        tx_load   = 1'b0;
        tx_byte   = 8'h00;
        accept    = 1'b0;
        next_elem = 1'b0;
        next_row  = 1'b0;
        dig_step  = 1'b0;
`ifdef PRINT_HEADER_EN
        hdr_step  = 1'b0;
`endif
        unique case (state)
            IDLE: if (start) begin
                accept = 1'b1;
`ifdef PRINT_HEADER_EN
                state_n = dims_ok ? TX_HDR : FINISH;
`else
                state_n = dims_ok ? FETCH : FINISH;
`endif
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_n = WAIT;
            end
            WAIT: state_n = CONV;
            CONV: state_n = TX_DIGIT;
            TX_DIGIT: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = {4'h3, cur_dig};
                if (dig_idx == 2'd0) state_n = last_col ? TX_CR : TX_SEP;
                else                 dig_step = 1'b1;
            end
            TX_SEP: if (tx_ready) begin
                tx_load   = 1'b1;
                tx_byte   = 8'h20;
                next_elem = 1'b1;
                state_n   = FETCH;
            end
            TX_CR: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = 8'h0D;
                state_n = TX_LF;
            end
            TX_LF: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = 8'h0A;
                if (last_row) begin
                    state_n = FINISH;
                end else begin
                    next_row = 1'b1;
                    state_n  = FETCH;
                end
            end
            FINISH: if (tx_ready) begin
                done    = 1'b1;
                state_n = IDLE;
            end
`ifdef PRINT_HEADER_EN
            TX_HDR: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = hdr_byte;
                if (hdr_idx == 3'd4) state_n = FETCH;
                else                 hdr_step = 1'b1;
            end
`endif
            default: state_n = IDLE;
        endcase
        if (rst) begin
            rd_en = 1'b0;
            done  = 1'b0;
        end
    end

    // Datapath: latched dimensions, element position, value and its digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r     <= 3'd0;
            n_r     <= 3'd0;
            row     <= 3'd0;
            col     <= 3'd0;
            addr    <= 5'd0;
            val     <= 8'd0;
            d2      <= 4'd0;
            d1      <= 4'd0;
            d0      <= 4'd0;
            dig_idx <= 2'd0;
            busy    <= 1'b0;
`ifdef PRINT_HEADER_EN
            hdr_idx <= 3'd0;
`endif
        end else begin
            if (accept) begin
                m_r  <= dim_m;
                n_r  <= dim_n;
                row  <= 3'd0;
                col  <= 3'd0;
                addr <= 5'd0;
                busy <= dims_ok;
`ifdef PRINT_HEADER_EN
                hdr_idx <= 3'd0;
`endif
            end
            if (state == WAIT) val <= rd_data;
            if (state == CONV) begin
                d2      <= 4'(val / 8'd100);
                d1      <= 4'((val / 8'd10) % 8'd10);
                d0      <= 4'(val % 8'd10);
                dig_idx <= (val >= 8'd100) ? 2'd2 :
                           (val >= 8'd10)  ? 2'd1 : 2'd0;
            end
            if (dig_step) dig_idx <= dig_idx - 2'd1;
            if (next_elem) begin
                addr <= addr + 5'd1;
                col  <= col + 3'd1;
            end
            if (next_row) begin
                addr <= addr + 5'd1;
                row  <= row + 3'd1;
                col  <= 3'd0;
            end
            if (done) busy <= 1'b0;
`ifdef PRINT_HEADER_EN
            if (hdr_step) hdr_idx <= hdr_idx + 3'd1;
`endif
        end
    end

    // UART shifter: start, 8 data bits LSB first, stop; each bit BIT_CYC cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_active <= 1'b0;
            uart_tx   <= 1'b1;
            frame     <= 10'h3FF;
            bit_cyc   <= '0;
            bit_idx   <= 4'd0;
        end else if (tx_load) begin
            tx_active <= 1'b1;
            uart_tx   <= 1'b0;
            frame     <= {1'b1, tx_byte, 1'b0};
            bit_cyc   <= '0;
            bit_idx   <= 4'd0;
        end else if (tx_active) begin
            if (bit_cyc == LAST_CYC) begin
                bit_cyc <= '0;
                if (bit_idx == 4'd9) begin
                    tx_active <= 1'b0;
                    uart_tx   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    uart_tx <= frame[1];
                    frame   <= {1'b1, frame[9:1]};
                end
            end else begin
                bit_cyc <= bit_cyc + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_uart_printer.sv
// tb_matrix_uart_printer: scoreboard bench; a UART monitor decodes frames and checks
// them against bytes queued by a printf-based reference model of the print format.
module tb_matrix_uart_printer;
    localparam int B     = 8;
    localparam int B_DEF = 868;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, start;
    logic [2:0] dim_m, dim_n;
    logic       rd_en, uart_tx, busy, done;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] mem [32];

    logic       rst2, start2;
    logic [2:0] dm2, dn2;
    logic       rd_en2, uart_tx2, busy2, done2;
    logic [4:0] rd_addr2;
    logic [7:0] rd_data2;

    matrix_uart_printer #(.CLK_FREQ(8000000), .BAUD_RATE(1000000)) dut (
        .clk(clk), .rst(rst), .start(start), .dim_m(dim_m), .dim_n(dim_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .uart_tx(uart_tx), .busy(busy), .done(done)
    );

    matrix_uart_printer dut_def (
        .clk(clk), .rst(rst2), .start(start2), .dim_m(dm2), .dim_n(dn2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .uart_tx(uart_tx2), .busy(busy2), .done(done2)
    );

    always @(posedge clk) rd_data <= mem[rd_addr];

    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    bit         last_q[$];
    int         addr_q[$];
    int   rd_cnt = 0;
    int   last_end = -100;
    int   prev_end = 0;
    bit   have_prev = 0;
    bit   prev_last = 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic get_frame(input bit w, input int b, output logic [7:0] bv,
                             output bit ok, output bit ab);
        logic [9:0] bits;
        logic s;
        ok = 1'b1;
        ab = 1'b0;
        bits = '0;
        bv = '0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < b; j++) begin
                if (i != 0 || j != 0) @(negedge clk);
                if (!w && rst) begin
                    ab = 1'b1;
                    return;
                end
                s = w ? uart_tx2 : uart_tx;
                if (j == 0) bits[i] = s;
                else if (s !== bits[i]) ok = 1'b0;
            end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
        bv = bits[8:1];
    endtask

    task automatic push_model(input int m, input int n);
        logic [7:0] q[$];
        string s;
`ifdef PRINT_HEADER_EN
        q.push_back(8'(48 + m));
        q.push_back(8'h20);
        q.push_back(8'(48 + n));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
`endif
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = $sformatf("%0d", mem[r*n + c]);
                for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
                if (c < n - 1) q.push_back(8'h20);
                addr_q.push_back(r*n + c);
            end
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        foreach (q[i]) begin
            exp_q.push_back(q[i]);
            last_q.push_back(i == q.size() - 1);
        end
    endtask

    // Frame monitor for the fast instance.
    initial begin
        logic [7:0] bv;
        logic [7:0] e;
        bit ok, ab, lf;
        int sc;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                sc = cyc;
                get_frame(1'b0, B, bv, ok, ab);
                if (ab) begin
                    have_prev = 1'b0;
                end else begin
                    chk("bit_timing", ok, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", bv, -1);
                    end else begin
                        e  = exp_q.pop_front();
                        lf = last_q.pop_front();
                        chk("tx_byte", bv, e);
                        if (have_prev && !prev_last)
                            chk("frame_gap_le2", (sc - prev_end - 1) <= 2, 1);
                        have_prev = 1'b1;
                        prev_last = lf;
                        prev_end  = cyc;
                        if (lf) last_end = cyc;
                    end
                end
            end
        end
    end

    // Read-strobe monitor: one read per element, row-major order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rd_en === 1'b1) begin
                rd_cnt++;
                if (addr_q.size() == 0) chk("unexpected_read", rd_addr, -1);
                else                    chk("rd_addr", rd_addr, addr_q.pop_front());
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0: mem[i] = 8'd0;
                    1: mem[i] = 8'd9;
                    2: mem[i] = 8'd10;
                    3: mem[i] = 8'd99;
                    4: mem[i] = 8'd100;
                    default: mem[i] = 8'd255;
                endcase
            end else begin
                mem[i] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic run_print(input int m, input int n, input bit poke);
        bit valid, seen, bz;
        int rd0, dc;
        valid = (m >= 1 && m <= 5 && n >= 1 && n <= 5);
        if (valid) push_model(m, n);
        rd0 = rd_cnt;
        @(negedge clk);
        start = 1'b1;
        dim_m = 3'(m);
        dim_n = 3'(n);
        @(negedge clk);
        start = 1'b0;
        dim_m = 3'($urandom);
        dim_n = 3'($urandom);
        if (!valid) begin
            chk("inv_done_1cyc", done, 1);
            chk("inv_busy", busy, 0);
            @(negedge clk);
            chk("inv_done_single", done, 0);
            bz = 1'b0;
            repeat (3*B) begin
                @(negedge clk);
                if (busy !== 1'b0) bz = 1'b1;
            end
            chk("inv_busy_low", bz, 0);
            chk("inv_no_read", rd_cnt - rd0, 0);
            return;
        end
        chk("busy_after_start", busy, 1);
        chk("no_early_done", done, 0);
        seen = 1'b0;
        for (int i = 0; i < 40000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (poke) begin
                start = (i == 40);
                dim_m = 3'($urandom);
                dim_n = 3'($urandom);
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (seen) begin
            dc = cyc;
            chk("done_after_lf_le2", (dc - last_end >= 1) && (dc - last_end <= 2), 1);
            chk("all_bytes_sent", exp_q.size(), 0);
            chk("read_count", rd_cnt - rd0, m*n);
            @(negedge clk);
            chk("done_single", done, 0);
            chk("busy_cleared", busy, 0);
        end
    endtask

    task automatic reset_mid_print();
        int total;
        bit hi, got;
        fill_random();
        push_model(2, 3);
        total = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        dim_m = 3'd2;
        dim_n = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        dim_m = 3'd1;
        dim_n = 3'd1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (exp_q.size() <= total - 2) got = 1'b1;
        end
        chk("two_bytes_before_rst", got, 1);
        repeat (4*B) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_high", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", rd_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        last_q.delete();
        addr_q.delete();
        have_prev = 1'b0;
        hi = 1'b1;
        repeat (12*B) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) hi = 1'b0;
        end
        chk("no_resume_after_rst", hi, 1);
        chk("idle_after_rst", busy, 0);
    endtask

    task automatic main_seq();
        int m, n;
        rst   = 1'b1;
        start = 1'b0;
        dim_m = 3'd0;
        dim_n = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_tx", uart_tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_addr", rd_addr, 0);
        rst = 1'b0;
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
        run_print(2, 2, 1'b0);
        mem[0] = 8'd0; mem[1] = 8'd10; mem[2] = 8'd255;
        run_print(1, 3, 1'b0);
        run_print(0, 2, 1'b0);
        run_print(6, 1, 1'b0);
        run_print(3, 0, 1'b0);
        run_print(7, 7, 1'b0);
        mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd7;
        mem[3] = 8'd8; mem[4] = 8'd9; mem[5] = 8'd2;
        run_print(3, 2, 1'b0);
        fill_random();
        run_print(5, 5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fill_random();
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            run_print(m, n, i == 2);
        end
        reset_mid_print();
        fill_random();
        run_print(2, 2, 1'b0);
    endtask

    task automatic def_seq();
        logic [7:0] q[$];
        logic [7:0] bv;
        bit ok, ab, seen;
        int idle;
        rst2     = 1'b1;
        start2   = 1'b0;
        dm2      = 3'd1;
        dn2      = 3'd1;
        rd_data2 = 8'd7;
`ifdef PRINT_HEADER_EN
        q = '{8'h31, 8'h20, 8'h31, 8'h0D, 8'h0A, 8'h37, 8'h0D, 8'h0A};
`else
        q = '{8'h37, 8'h0D, 8'h0A};
`endif
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("def_busy", busy2, 1);
        foreach (q[k]) begin
            idle = 0;
            while (uart_tx2 !== 1'b0 && idle < 60) begin
                @(negedge clk);
                if (uart_tx2 !== 1'b0) idle++;
            end
            if (k > 0) chk("def_gap_le2", idle <= 2, 1);
            chk("def_start_bit", uart_tx2, 0);
            get_frame(1'b1, B_DEF, bv, ok, ab);
            chk("def_bit_868", ok, 1);
            chk("def_byte", bv, q[k]);
            @(negedge clk);
        end
        seen = done2;
        if (!seen) begin
            @(negedge clk);
            seen = done2;
        end
        chk("def_done", seen, 1);
    endtask

    initial begin
        fork
            main_seq();
            def_seq();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_uart_printer.md
MATRIX_UART_PRINTER -- requirements
Module: matrix_uart_printer

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, UART bit rate; bit period BIT_CYC = CLK_FREQ/BAUD_RATE (868 at defaults).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to print the matrix.
REQ-006 dim_m  input  3  row count, latched on accepted start.
REQ-007 dim_n  input  3  column count, latched on accepted start.
REQ-008 rd_en  output  1  element-read strobe to matrix storage.
REQ-009 rd_addr  output  5  element address, row-major: r*n + c.
REQ-010 rd_data  input  8  unsigned element, valid the cycle after rd_en.
REQ-011 uart_tx  output  1  serial line: 8N1, LSB first, idle high.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle pulse when printing completes or is rejected.

Function
REQ-014 The block SHALL accept start only when busy=0; start while busy=1 SHALL be ignored.
REQ-015 Dimensions SHALL be valid for 1..5; if dim_m or dim_n is 0 or greater than 5, the block SHALL emit no bytes and pulse done exactly 1 cycle after start, with busy staying 0.
REQ-016 Output format: row elements in decimal ASCII, separated by one 0x20; each row terminated by 0x0D 0x0A; no trailing space.
REQ-017 Decimal conversion SHALL print 1 to 3 digits with no leading zeros; value 0 prints "0" and 255 prints "255".
REQ-018 The block SHALL issue exactly one rd_en per element, in row-major order, and never read past address m*n-1.
REQ-019 FSM states: IDLE, FETCH, WAIT, CONV, TX_DIGIT, TX_SEP, TX_CR, TX_LF, FINISH; FINISH pulses done, clears busy, and returns to IDLE.
REQ-020 Each UART frame SHALL be start bit 0, 8 data bits, stop bit 1, each held exactly BIT_CYC cycles.
REQ-021 The gap between consecutive frames within one print SHALL be at most 2 idle-high cycles, measured from the stop bit end to the next start bit.
REQ-022 done SHALL assert within 2 cycles after the final LF stop bit completes.
REQ-023 Matrix inputs SHALL be sampled only on an accepted start; later changes to dim_m or dim_n SHALL not affect the print in progress.

Reset
REQ-024 While rst=1: uart_tx=1, busy=0, done=0, rd_en=0, rd_addr=0, and the FSM in IDLE.
REQ-025 rst asserted mid-frame SHALL abort the print; uart_tx SHALL be high on the next cycle, and no partial frame SHALL resume after release.

Configuration
REQ-026 Macro PRINT_HEADER_EN: when defined, each valid print SHALL be preceded by a header of the ASCII m digit, 0x20, the ASCII n digit, 0x0D, 0x0A.
REQ-027 When PRINT_HEADER_EN is not defined, the block SHALL emit no header, and no header logic SHALL be present.

Verification
REQ-028 2x2 with elements {1,2,3,4}, no macro -> bytes 31 20 32 0D 0A 33 20 34 0D 0A, then a single done pulse.
REQ-029 1x3 with elements {0,10,255} -> bytes 30 20 31 30 20 32 35 35 0D 0A; rd_addr sequence 0,1,2.
REQ-030 dim_m=0, dim_n=2 -> no start bit on uart_tx, done 1 cycle after start, rd_en never asserted.
REQ-031 Second start during busy, then rst in the middle of byte 3 -> second start ignored; uart_tx=1 and busy=0 on the cycle after rst; next start prints normally.
REQ-032 PRINT_HEADER_EN defined, 3x2 with elements {5,6,7,8,9,2} -> 33 20 32 0D 0A, then 35 20 36 0D 0A 37 20 38 0D 0A 39 20 32 0D 0A.
REQ-033 Bit timing check at defaults -> every bit lasts exactly 868 cycles, and inter-frame gaps are at most 2 cycles.
